// File: rtl/ahb_apb_pkg.sv
// rtl/ahb_apb_pkg.sv - shared encodings, FSM states and byte-lane helpers for the AHB-to-APB bridge
package ahb_apb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WDATA,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // 2^size ones, sized for the widest (64-bit) data bus
  function automatic logic [7:0] size_ones(input logic [2:0] size);
    logic [7:0] m;
    case (size)
      3'd0:    m = 8'h01;
      3'd1:    m = 8'h03;
      3'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

  function automatic logic [7:0] strb_mask(input logic [2:0] size, input logic [2:0] offset);
    return size_ones(size) << offset;
  endfunction

  function automatic logic is_aligned(input logic [2:0] size, input logic [2:0] offset);
    logic [2:0] low;
    case (size)
      3'd0:    low = 3'd0;
      3'd1:    low = 3'd1;
      3'd2:    low = 3'd3;
      default: low = 3'd7;
    endcase
    return (offset & low) == 3'd0;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// rtl/apb_slave_decode.sv - maps an AHB address onto a one-hot APB slave select
module apb_slave_decode
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 24
) (
  input  logic [ADDR_W-1:0]  haddr,
  output logic [NUM_SLV-1:0] sel,
  output logic               valid
);

  logic [ADDR_W-1:0] offset;
  logic [ADDR_W-1:0] idx;

  always_comb begin
    offset = haddr - BASE_ADDR;
    idx    = offset >> REGION_BITS;
    sel    = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      sel[i] = (haddr >= BASE_ADDR) && (idx == ADDR_W'(i));
    end
    valid = |sel;
  end

endmodule

// File: rtl/ahb2apb_bridge_param.sv
// rtl/ahb2apb_bridge_param.sv - parametrised AHB-to-APB3/APB4 bridge with decode errors and a PREADY watchdog
module ahb2apb_bridge_param
  import ahb_apb_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                REGION_BITS = 24,
  parameter int                TIMEOUT     = 255
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic [ADDR_W-1:0]     HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_W-1:0]     HWDATA,
  input  logic                  HREADYin,
  output logic                  HREADYout,
  output logic [1:0]            HRESP,
  output logic [DATA_W-1:0]     HRDATA,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int              STRB_W   = DATA_W / 8;
  localparam int              OFF_W    = $clog2(STRB_W);
  localparam logic [2:0]      MAX_SIZE = 3'(OFF_W);
  localparam int              WD_W     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_MAX   = WD_W'(TIMEOUT);

  state_e              state_q, state_d;
  logic [2:0]          hsize_q, hsize_d;
  logic [NUM_SLV-1:0]  sel_q, sel_d;
  logic                hreadyout_q, hreadyout_d;
  logic [1:0]          hresp_q, hresp_d;
  logic [DATA_W-1:0]   hrdata_q, hrdata_d;
  logic [ADDR_W-1:0]   paddr_q, paddr_d;
  logic [DATA_W-1:0]   pwdata_q, pwdata_d;
  logic [STRB_W-1:0]   pstrb_q, pstrb_d;
  logic [NUM_SLV-1:0]  psel_q, psel_d;
  logic                penable_q, penable_d;
  logic                pwrite_q, pwrite_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic [NUM_SLV-1:0]  dec_sel;
  logic                dec_valid;
  logic [2:0]          off_in, off_q;
  logic                accept, req_ok;

  apb_slave_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_SLV     (NUM_SLV),
    .BASE_ADDR   (BASE_ADDR),
    .REGION_BITS (REGION_BITS)
  ) u_decode (
    .haddr (HADDR),
    .sel   (dec_sel),
    .valid (dec_valid)
  );

  always_comb begin
    off_in = '0;
    off_in[OFF_W-1:0] = HADDR[OFF_W-1:0];
    off_q = '0;
    off_q[OFF_W-1:0] = paddr_q[OFF_W-1:0];
    accept = HREADYin && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    req_ok = dec_valid && (HSIZE <= MAX_SIZE) && is_aligned(HSIZE, off_in);
  end

  always_comb begin
    state_d     = state_q;
    hsize_d     = hsize_q;
    sel_d       = sel_q;
    hreadyout_d = hreadyout_q;
    hresp_d     = hresp_q;
    hrdata_d    = hrdata_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    pstrb_d     = pstrb_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    wd_d        = '0;

    case (state_q)
      ST_IDLE, ST_ERR2: begin
        hresp_d     = HRESP_OKAY;
        hreadyout_d = 1'b1;
        state_d     = ST_IDLE;
        if (accept) begin
          hreadyout_d = 1'b0;
          if (!req_ok) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            hsize_d  = HSIZE;
            sel_d    = dec_sel;
            paddr_d  = HADDR;
            pwrite_d = HWRITE;
            if (HWRITE) begin
              state_d = ST_WDATA;
            end else begin
              // reads skip the data-phase capture and go straight to SETUP
              psel_d  = dec_sel;
              pstrb_d = '0;
              state_d = ST_SETUP;
            end
          end
        end
      end
      ST_WDATA: begin
        pwdata_d = HWDATA;
        pstrb_d  = STRB_W'(strb_mask(hsize_q, off_q));
        psel_d   = sel_q;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY && !PSLVERR) begin
          if (!pwrite_q) hrdata_d = PRDATA;
          hreadyout_d = 1'b1;
          psel_d      = '0;
          penable_d   = 1'b0;
          state_d     = ST_IDLE;
        end else if (PREADY || (TIMEOUT > 0 && wd_q == WD_MAX)) begin
          psel_d    = '0;
          penable_d = 1'b0;
          hresp_d   = HRESP_ERROR;
          state_d   = ST_ERR1;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      ST_ERR1: begin
        hresp_d     = HRESP_ERROR;
        hreadyout_d = 1'b1;
        state_d     = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q     <= ST_IDLE;
      hsize_q     <= '0;
      sel_q       <= '0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= '0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      hsize_q     <= hsize_d;
      sel_q       <= sel_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      pstrb_q     <= pstrb_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      wd_q        <= wd_d;
    end
  end

  assign HREADYout = hreadyout_q;
  assign HRESP     = hresp_q;
  assign HRDATA    = hrdata_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;

endmodule

// File: tb/tb_ahb2apb_bridge_param.sv
// tb/tb_ahb2apb_bridge_param.sv - scoreboard bench for the parametrised AHB-to-APB bridge
`timescale 1ns/1ps
module tb_ahb2apb_bridge_param;
  import ahb_apb_pkg::*;

  localparam int TO = 4;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYin;
  logic        HREADYout;
  logic [1:0]  HRESP;
  logic [31:0] HRDATA;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  ahb2apb_bridge_param #(
    .ADDR_W      (32),
    .DATA_W      (32),
    .NUM_SLV     (3),
    .BASE_ADDR   (32'h8000_0000),
    .REGION_BITS (24),
    .TIMEOUT     (TO)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HWRITE    (HWRITE),
    .HSIZE     (HSIZE),
    .HWDATA    (HWDATA),
    .HREADYin  (HREADYin),
    .HREADYout (HREADYout),
    .HRESP     (HRESP),
    .HRDATA    (HRDATA),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .PSLVERR   (PSLVERR)
  );

  always #5 HCLK = ~HCLK;
  assign HREADYin = HREADYout;

  typedef struct {
    logic        err;
    int          lat;
    logic [31:0] rdata;
    logic [2:0]  sel;
    int          psel_cyc;
    logic [3:0]  strb;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd  = 32'h0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  function automatic exp_t model(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                                 input int waits, input logic slverr, input logic [31:0] prdata,
                                 input logic [31:0] prev_rd);
    exp_t        e;
    logic [31:0] off;
    int          idx;
    int          nbytes;
    int          eff;
    logic        ok;
    off    = addr - 32'h8000_0000;
    idx    = int'(off >> 24);
    nbytes = 1 << size;
    ok     = (addr >= 32'h8000_0000) && (idx < 3) && (size <= 3'd2) && ((addr & 32'(nbytes - 1)) == 32'h0);
    e.sel  = ok ? 3'(1 << idx) : 3'b000;
    e.strb = (ok && wr) ? 4'(((1 << nbytes) - 1) << addr[1:0]) : 4'b0000;
    if (!ok) begin
      e.err      = 1'b1;
      e.lat      = 1;
      e.psel_cyc = 0;
    end else begin
      eff        = (waits > TO) ? TO : waits;
      e.err      = slverr || (waits > TO);
      e.lat      = (wr ? 4 : 3) + eff;
      e.psel_cyc = eff + 2;
    end
    e.rdata = (ok && !wr && !e.err) ? prdata : prev_rd;
    return e;
  endfunction

  task automatic ahb_xfer(input logic [31:0] addr, input logic wr, input logic [2:0] size,
                          input logic [31:0] wdata, input int waits, input logic slverr,
                          input logic [31:0] prdata);
    exp_t e;
    int   acc;
    int   psel_n;
    bit   done;
    e = model(addr, wr, size, waits, slverr, prdata, last_rd);
    last_rd = e.rdata;
    exp_q.push_back(e);

    HADDR   = addr;
    HWRITE  = wr;
    HSIZE   = size;
    HTRANS  = HTRANS_NONSEQ;
    PRDATA  = prdata;
    PSLVERR = slverr;
    PREADY  = 1'b0;
    tick;
    HTRANS  = HTRANS_IDLE;
    HWDATA  = wdata;
    HADDR   = 32'hDEAD_BEE0;
    HWRITE  = ~wr;

    acc = 0;
    psel_n = 0;
    done = 0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (PSEL != 3'b000) begin
        psel_n++;
        check_eq("psel", 64'(PSEL), 64'(exp_q[0].sel));
        check_eq("paddr", 64'(PADDR), 64'(addr));
        check_eq("pwrite", 64'(PWRITE), 64'(wr));
        check_eq("pstrb", 64'(PSTRB), 64'(exp_q[0].strb));
        if (wr) check_eq("pwdata", 64'(PWDATA), 64'(wdata));
      end
      if (PSEL != 3'b000 && PENABLE) begin
        acc++;
        PREADY = (acc > waits);
      end else begin
        PREADY = 1'b0;
      end
      if (HRESP == HRESP_ERROR || HREADYout) begin
        done = 1;
        e = exp_q.pop_front();
        check_eq("resp_err", 64'(HRESP == HRESP_ERROR), 64'(e.err));
        check_eq("latency", 64'(c), 64'(e.lat));
        check_eq("hrdata", 64'(HRDATA), 64'(e.rdata));
        check_eq("psel_cycles", 64'(psel_n), 64'(e.psel_cyc));
        check_eq("apb_idle_at_resp", 64'({PSEL, PENABLE}), 64'd0);
        PREADY = 1'b0;
        if (HRESP == HRESP_ERROR) begin
          check_eq("err1_hready", 64'(HREADYout), 64'd0);
          tick;
          check_eq("err2_resp", 64'({HRESP, HREADYout}), 64'b011);
          tick;
          check_eq("post_err_resp", 64'({HRESP, HREADYout}), 64'b001);
        end
      end else begin
        tick;
      end
    end
    if (!done) begin
      check_eq("xfer_timeout", 64'd0, 64'd1);
      void'(exp_q.pop_front());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hready_resp"}, 64'({HRESP, HREADYout}), 64'b001);
    check_eq({tag, "_hrdata"}, 64'(HRDATA), 64'd0);
    check_eq({tag, "_apb_ctl"}, 64'({PSEL, PENABLE, PWRITE}), 64'd0);
    check_eq({tag, "_paddr"}, 64'(PADDR), 64'd0);
    check_eq({tag, "_pwdata_pstrb"}, 64'({PWDATA, PSTRB}), 64'd0);
  endtask

  initial begin
    HRESETn = 1'b0;
    HADDR   = '0;
    HTRANS  = HTRANS_IDLE;
    HWRITE  = 1'b0;
    HSIZE   = 3'd0;
    HWDATA  = '0;
    PRDATA  = '0;
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    tick;
    tick;
    HRESETn = 1'b1;
    check_reset_outputs("reset");

    HTRANS = HTRANS_BUSY;
    tick;
    check_eq("busy_no_action", 64'({PSEL, HRESP, HREADYout}), 64'b000001);
    HTRANS = HTRANS_IDLE;

    ahb_xfer(32'h8100_0004, 1'b0, 3'd2, 32'h0,         0, 1'b0, 32'h0000_001F);
    ahb_xfer(32'h8000_0002, 1'b1, 3'd1, 32'h0005_0000, 3, 1'b0, 32'h0);
    ahb_xfer(32'h8300_0000, 1'b0, 3'd2, 32'h0,         0, 1'b0, 32'h1234_5678);
    ahb_xfer(32'h8200_0010, 1'b0, 3'd2, 32'h0,         1, 1'b1, 32'hCAFE_0001);
    ahb_xfer(32'h8000_0100, 1'b0, 3'd2, 32'h0,         8, 1'b0, 32'hCAFE_0002);
    ahb_xfer(32'h8000_0002, 1'b1, 3'd2, 32'hFFFF_FFFF, 0, 1'b0, 32'h0);
    ahb_xfer(32'h8200_0001, 1'b1, 3'd0, 32'h0000_AB00, 0, 1'b0, 32'h0);
    ahb_xfer(32'h7FFF_FFFC, 1'b0, 3'd2, 32'h0,         0, 1'b0, 32'h5555_5555);
    ahb_xfer(32'h8000_0000, 1'b0, 3'd3, 32'h0,         0, 1'b0, 32'h6666_6666);
    ahb_xfer(32'h8000_0008, 1'b0, 3'd2, 32'h0,         4, 1'b0, 32'hA5A5_0F0F);
    ahb_xfer(32'h8100_0006, 1'b1, 3'd1, 32'h1234_0000, 2, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      ahb_xfer(32'h8000_0000 + (32'(i % 3) << 24) + 32'(i * 4), 1'(i % 2), 3'd2,
               $urandom, i, 1'b0, $urandom);
    end

    HADDR  = 32'h8000_0040;
    HWRITE = 1'b0;
    HSIZE  = 3'd2;
    HTRANS = HTRANS_NONSEQ;
    PREADY = 1'b0;
    tick;
    HTRANS = HTRANS_IDLE;
    for (int c = 0; c < 10 && !(PSEL != 3'b000 && PENABLE); c++) tick;
    check_eq("reached_access", 64'(PENABLE), 64'd1);
    HRESETn = 1'b0;
    tick;
    HRESETn = 1'b1;
    last_rd = 32'h0;
    check_reset_outputs("mid_reset");

    ahb_xfer(32'h8100_0004, 1'b0, 3'd2, 32'h0, 0, 1'b0, 32'h0000_0777);

    check_eq("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
